// File: rtl/dmem_store_buffer.sv
// Posted-store buffer between the core data port and a req/ack data SRAM; loads hit the FIFO or read the SRAM.
// Optional build macro STBUF_FWD_EN enables store-to-load forwarding; without it, matching loads wait for a full drain.
module dmem_store_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     core_wr,
    input  logic                     core_rd,
    input  logic [ADDR_W-1:0]        core_addr,
    input  logic [DATA_W-1:0]        core_wdata,
    output logic [DATA_W-1:0]        core_rdata,
    output logic                     core_stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   buf_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, LOAD = 2'd2, RESP = 2'd3} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   resp_q, resp_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   ent_addr_q [DEPTH];
    logic [DATA_W-1:0]   ent_data_q [DEPTH];

    logic push, pop, load_resp, match, full, rd_active, miss_req;
`ifdef STBUF_FWD_EN
    logic                capture;
    logic [DATA_W-1:0]   fwd_data;
`endif

    assign full      = (count_q == CNT_W'(DEPTH));
    // done_q marks a combined load+store whose load half has already been served.
    assign rd_active = core_rd && !done_q;
    assign miss_req  = rd_active && !match;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        match = 1'b0;
`ifdef STBUF_FWD_EN
        fwd_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q && ent_addr_q[idx] == core_addr) begin
                match = 1'b1;
`ifdef STBUF_FWD_EN
                fwd_data = ent_data_q[idx];
`endif
            end
        end
    end

    // NOTE: every signal gets a default before the branches so no latch is inferred.
    always_comb begin
        core_stall = 1'b0;
        core_rdata = '0;
        push       = 1'b0;
        done_d     = done_q;
`ifdef STBUF_FWD_EN
        capture    = 1'b0;
`endif
        if (rd_active) begin
            if (state_q == RESP) begin
                core_rdata = resp_q;
                if (core_wr) begin
                    core_stall = 1'b1;
                    done_d     = 1'b1;
                end
            end
`ifdef STBUF_FWD_EN
            else if (match) begin
                core_rdata = fwd_data;
                if (core_wr) begin
                    core_stall = 1'b1;
                    done_d     = 1'b1;
                    capture    = 1'b1;
                end
            end
`endif
            else begin
                core_stall = 1'b1;
            end
        end else if (core_wr) begin
            if (done_q) core_rdata = resp_q;
            if (full) begin
                core_stall = 1'b1;
            end else begin
                push   = 1'b1;
                done_d = 1'b0;
            end
        end else begin
            done_d = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pop         = 1'b0;
        load_resp   = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_req) begin
                    state_d    = LOAD;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = core_addr;
                end else if (count_q != '0) begin
                    state_d     = DRAIN;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ent_addr_q[rd_ptr_q];
                    mem_wdata_d = ent_data_q[rd_ptr_q];
                end
            end
            DRAIN: if (mem_ack) begin
                pop       = 1'b1;
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
            LOAD: if (mem_ack) begin
                load_resp = 1'b1;
                mem_req_d = 1'b0;
                state_d   = RESP;
            end
            RESP:    state_d = IDLE;
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        resp_d = resp_q;
        if (load_resp) resp_d = mem_rdata;
`ifdef STBUF_FWD_EN
        else if (capture) resp_d = fwd_data;
`endif
    end

    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            resp_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            resp_q      <= resp_d;
            done_q      <= done_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // NOTE: entry storage has no reset; validity comes solely from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= core_addr;
            ent_data_q[wr_ptr_q] <= core_wdata;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign buf_count = count_q;
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed self-checking bench for dmem_store_buffer; covers both STBUF_FWD_EN builds.
module tb_dmem_store_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_wr = 1'b0, core_rd = 1'b0;
    logic [8:0]  core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        mem_req, mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [2:0]  buf_count;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [8:0] a; logic [31:0] d; } wr_t;
    wr_t         wr_log [$];
    logic [31:0] sram [512];

    dmem_store_buffer dut (
        .clk(clk), .reset(reset), .core_wr(core_wr), .core_rd(core_rd),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_stall(core_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && mem_req && mem_ack && mem_we) begin
            wr_log.push_back('{a: mem_addr, d: mem_wdata});
            sram[mem_addr] = mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        int n = 0;
        while (buf_count != 0 && n < 200) begin
            if (mem_req && mem_we) mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            n++;
        end
        checks++;
        if (buf_count !== 3'd0) begin errors++; $display("FAIL drain_timeout got=%0d exp=0", buf_count); end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({core_stall, mem_req, mem_we, mem_addr, mem_wdata, buf_count, core_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs stall=%b req=%b we=%b addr=%h wdata=%h cnt=%0d rdata=%h exp all 0",
                     core_stall, mem_req, mem_we, mem_addr, mem_wdata, buf_count, core_rdata);
        end
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        tick();
    endtask

    task automatic test_store_drain();
        wr_log.delete();
        core_wr = 1'b1; core_addr = 9'h010; core_wdata = 32'h1A5A5A5A;
        #1;
        checks++;
        if (core_stall !== 1'b0) begin errors++; $display("FAIL t1_stall got=%b exp=0", core_stall); end
        tick();
        core_wr = 1'b0;
        #1;
        checks++;
        if (buf_count !== 3'd1) begin errors++; $display("FAIL t1_count1 got=%0d exp=1", buf_count); end
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 9'h010, 32'h1A5A5A5A}) begin
            errors++;
            $display("FAIL t1_write_req req=%b we=%b addr=%h data=%h exp 1 1 010 1a5a5a5a", mem_req, mem_we, mem_addr, mem_wdata);
        end
        tick(); tick();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 9'h010}) begin
            errors++; $display("FAIL t1_req_held req=%b addr=%h exp 1 010", mem_req, mem_addr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({mem_req, buf_count} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL t1_after_ack req=%b cnt=%0d exp 0 0", mem_req, buf_count);
        end
        checks++;
        if (wr_log.size() != 1 || wr_log[0].a !== 9'h010 || wr_log[0].d !== 32'h1A5A5A5A) begin
            errors++; $display("FAIL t1_sram_write entries=%0d exp 1 @010=1a5a5a5a", wr_log.size());
        end
        tick();
    endtask

    task automatic test_back_to_back();
        wr_log.delete();
        for (int i = 0; i < 4; i++) begin
            core_wr = 1'b1; core_addr = 9'h020 + 9'(i); core_wdata = 32'h100 + 32'(i);
            #1;
            checks++;
            if (core_stall !== 1'b0) begin errors++; $display("FAIL t2_stall_%0d got=%b exp=0", i, core_stall); end
            tick();
        end
        core_addr = 9'h024; core_wdata = 32'h104;
        #1;
        checks++;
        if ({core_stall, buf_count} !== {1'b1, 3'd4}) begin
            errors++; $display("FAIL t2_full_stall stall=%b cnt=%0d exp 1 4", core_stall, buf_count);
        end
        tick();
        mem_ack = 1'b1;
        #1;
        checks++;
        if (core_stall !== 1'b1) begin errors++; $display("FAIL t2_stall_during_ack got=%b exp=1", core_stall); end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({core_stall, buf_count} !== {1'b0, 3'd3}) begin
            errors++; $display("FAIL t2_stall_lifted stall=%b cnt=%0d exp 0 3", core_stall, buf_count);
        end
        tick();
        core_wr = 1'b0;
        #1;
        checks++;
        if (buf_count !== 3'd4) begin errors++; $display("FAIL t2_fifth_pushed got=%0d exp=4", buf_count); end
        drain_all();
        checks++;
        if (wr_log.size() != 5) begin
            errors++; $display("FAIL t2_write_count got=%0d exp=5", wr_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wr_log[i].a !== 9'h020 + 9'(i) || wr_log[i].d !== 32'h100 + 32'(i)) begin
                    errors++;
                    $display("FAIL t2_order_%0d got=%h/%h exp=%h/%h", i, wr_log[i].a, wr_log[i].d,
                             9'h020 + 9'(i), 32'h100 + 32'(i));
                end
            end
        end
        tick();
    endtask

    task automatic test_forward();
        wr_log.delete();
        core_wr = 1'b1; core_addr = 9'h005; core_wdata = 32'h11;
        tick();
        core_wdata = 32'h22;
        tick();
        core_wr = 1'b0; core_rd = 1'b1;
        #1;
`ifdef STBUF_FWD_EN
        checks++;
        if ({core_stall, core_rdata} !== {1'b0, 32'h22}) begin
            errors++; $display("FAIL t3_fwd stall=%b rdata=%h exp 0 00000022", core_stall, core_rdata);
        end
        core_rd = 1'b0;
        drain_all();
`else
        checks++;
        if (core_stall !== 1'b1) begin errors++; $display("FAIL t3_match_stall got=%b exp=1", core_stall); end
        for (int n = 0; n < 60; n++) begin
            if (!core_stall) break;
            if (mem_req) begin
                mem_ack = 1'b1;
                if (!mem_we) mem_rdata = sram[mem_addr];
            end
            tick();
            mem_ack = 1'b0;
            #1;
        end
        checks++;
        if ({core_stall, core_rdata, buf_count} !== {1'b0, 32'h22, 3'd0}) begin
            errors++; $display("FAIL t3_drain_then_load stall=%b rdata=%h cnt=%0d exp 0 00000022 0",
                               core_stall, core_rdata, buf_count);
        end
        core_rd = 1'b0;
        mem_rdata = '0;
`endif
        checks++;
        if (wr_log.size() != 2 || wr_log[0].d !== 32'h11 || wr_log[1].d !== 32'h22) begin
            errors++; $display("FAIL t3_write_order entries=%0d exp 2 (11 then 22)", wr_log.size());
        end
        tick();
    endtask

    task automatic test_load_miss();
        core_rd = 1'b1; core_addr = 9'h100;
        #1;
        checks++;
        if (core_stall !== 1'b1) begin errors++; $display("FAIL t4_stall0 got=%b exp=1", core_stall); end
        tick();
        checks++;
        if ({core_stall, mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 9'h100}) begin
            errors++; $display("FAIL t4_read_req stall=%b req=%b we=%b addr=%h exp 1 1 0 100",
                               core_stall, mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        checks++;
        if ({core_stall, core_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL t4_resp stall=%b rdata=%h exp 0 deadbeef", core_stall, core_rdata);
        end
        core_rd = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL t4_req_drop got=%b exp=0", mem_req); end
    endtask

    task automatic test_wr_rd_together();
        wr_log.delete();
        core_wr = 1'b1; core_rd = 1'b1; core_addr = 9'h0C0; core_wdata = 32'h55550001;
        #1;
        checks++;
        if (core_stall !== 1'b1) begin errors++; $display("FAIL t6_stall0 got=%b exp=1", core_stall); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        checks++;
        if ({core_stall, buf_count} !== {1'b1, 3'd0}) begin
            errors++; $display("FAIL t6_resp_cycle stall=%b cnt=%0d exp 1 0", core_stall, buf_count);
        end
        tick();
        checks++;
        if ({core_stall, core_rdata, buf_count} !== {1'b0, 32'hCAFEF00D, 3'd0}) begin
            errors++; $display("FAIL t6_push_cycle stall=%b rdata=%h cnt=%0d exp 0 cafef00d 0",
                               core_stall, core_rdata, buf_count);
        end
        tick();
        core_wr = 1'b0; core_rd = 1'b0;
        #1;
        checks++;
        if (buf_count !== 3'd1) begin errors++; $display("FAIL t6_count got=%0d exp=1", buf_count); end
        drain_all();
        checks++;
        if (wr_log.size() != 1 || wr_log[0].a !== 9'h0C0 || wr_log[0].d !== 32'h55550001) begin
            errors++; $display("FAIL t6_store_written entries=%0d exp 1 @0c0=55550001", wr_log.size());
        end
        tick();
    endtask

    task automatic test_async_reset();
        wr_log.delete();
        for (int i = 0; i < 3; i++) begin
            core_wr = 1'b1; core_addr = 9'h030 + 9'(i); core_wdata = 32'hA0 + 32'(i);
            tick();
        end
        core_wr = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, buf_count} !== {1'b1, 1'b1, 3'd3}) begin
            errors++; $display("FAIL t5_pre req=%b we=%b cnt=%0d exp 1 1 3", mem_req, mem_we, buf_count);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({mem_req, buf_count, mem_addr, mem_wdata} !== '0) begin
            errors++; $display("FAIL t5_async req=%b cnt=%0d addr=%h wdata=%h exp all 0",
                               mem_req, buf_count, mem_addr, mem_wdata);
        end
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            mem_ack = mem_req;
        end
        tick();
        mem_ack = 1'b0;
        checks++;
        if (wr_log.size() != 0 || mem_req !== 1'b0 || buf_count !== 3'd0) begin
            errors++; $display("FAIL t5_no_write writes=%0d req=%b cnt=%0d exp 0 0 0", wr_log.size(), mem_req, buf_count);
        end
    endtask

    initial begin
        test_reset();
        test_store_drain();
        test_back_to_back();
        test_forward();
        test_load_miss();
        test_wr_rd_together();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
